// File: rtl/txl_pop_scheduler.sv
// -----------------------------------------------------------------------------
// txl_pop_scheduler
//
// Round-robin pop scheduler for the transaction-layer virtual-channel FIFOs.
// Pops at most one word per cycle from four fifo_c queues and forwards it
// through a two-stage registered path into a single downstream FIFO. Popping
// is gated combinationally by the downstream almost-full flag. The block also
// owns the almost-full / almost-empty threshold registers fanned out to the
// queues, and latches a sticky ERROR state on any queue error.
//
// Ports
//   clk               single clock, all state updates on posedge
//   reset             synchronous reset, active-high
//   init              forces INIT; thresholds load from *_in while in INIT
//   umbral_af_in      almost-full threshold captured in INIT
//   umbral_ae_in      almost-empty threshold captured in INIT
//   fifo_empty        per-queue empty flags (bit i = queue i)
//   fifo_error        per-queue error flags
//   fifo_valid        per-queue valid_out_c (read data valid)
//   fifo_data         per-queue read data, queue i at [i*DW +: DW]
//   dest_almost_full  downstream FIFO almost-full flag
//   pop               one-hot (or zero) pop request to the queues
//   data_out          forwarded word
//   valid_out         data_out valid this cycle
//   umbral_af_out     almost-full threshold register
//   umbral_ae_out     almost-empty threshold register
//   state             one-hot FSM state
//   idle              IDLE with an empty output pipeline
//   error_out         high while in ERROR
//   words_fwd         forwarded-word counter, wraps at 255
//
// States
//   state  | meaning
//   RESET  | held by reset; leaves to INIT as soon as reset drops
//   INIT   | thresholds track *_in every cycle; exits to IDLE when init=0
//   IDLE   | nothing to pop; waits for a non-empty queue
//   ACTIVE | popping one word per cycle in round-robin order
//   PAUSE  | downstream almost full; popping suspended
//   ERROR  | sticky after any queue error; only reset leaves it
// -----------------------------------------------------------------------------
module txl_pop_scheduler #(
  parameter int unsigned DW         = 6,
  parameter logic [3:0]  AF_DEFAULT = 4'd6,
  parameter logic [3:0]  AE_DEFAULT = 4'd2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            init,
  input  logic [3:0]      umbral_af_in,
  input  logic [3:0]      umbral_ae_in,
  input  logic [3:0]      fifo_empty,
  input  logic [3:0]      fifo_error,
  input  logic [3:0]      fifo_valid,
  input  logic [4*DW-1:0] fifo_data,
  input  logic            dest_almost_full,
  output logic [3:0]      pop,
  output logic [DW-1:0]   data_out,
  output logic            valid_out,
  output logic [3:0]      umbral_af_out,
  output logic [3:0]      umbral_ae_out,
  output logic [5:0]      state,
  output logic            idle,
  output logic            error_out,
  output logic [7:0]      words_fwd
);

  typedef enum logic [5:0] {
    S_RESET  = 6'b000001,
    S_INIT   = 6'b000010,
    S_IDLE   = 6'b000100,
    S_ACTIVE = 6'b001000,
    S_PAUSE  = 6'b010000,
    S_ERROR  = 6'b100000
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [1:0]    r_last;
  logic          r_pop_d;
  logic [1:0]    r_grant_d;
  logic [DW-1:0] r_data_out;
  logic          r_valid_out;
  logic [7:0]    r_words_fwd;
  logic [3:0]    r_umbral_af;
  logic [3:0]    r_umbral_ae;

  logic          w_any_ready;
  logic          w_any_error;
  logic          w_pop_en;
  logic [1:0]    w_sel;
  logic          w_found;
  logic [1:0]    w_cand;
  logic [DW-1:0] w_data_sel;

  assign w_any_ready = ~&fifo_empty;
  assign w_any_error = |fifo_error;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_RESET;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == S_RESET) begin
      w_state_nxt = S_INIT;
    end else if (w_any_error) begin
      w_state_nxt = S_ERROR;
    end else begin
      case (r_state)
        S_INIT: begin
          if (!init) w_state_nxt = S_IDLE;
        end
        S_IDLE: begin
          if (init)             w_state_nxt = S_INIT;
          else if (w_any_ready) w_state_nxt = dest_almost_full ? S_PAUSE : S_ACTIVE;
        end
        S_ACTIVE: begin
          if (init)              w_state_nxt = S_INIT;
          else if (dest_almost_full) w_state_nxt = S_PAUSE;
          else if (!w_any_ready) w_state_nxt = S_IDLE;
        end
        S_PAUSE: begin
          if (init)                  w_state_nxt = S_INIT;
          else if (!dest_almost_full) w_state_nxt = w_any_ready ? S_ACTIVE : S_IDLE;
        end
        S_ERROR: w_state_nxt = S_ERROR;
        default: w_state_nxt = S_RESET;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin select: first non-empty queue after the last one granted.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_sel   = r_last;
    w_found = 1'b0;
    w_cand  = r_last;
    for (int k = 1; k <= 4; k++) begin
      w_cand = r_last + 2'(k);
      if (!w_found && !fifo_empty[w_cand]) begin
        w_sel   = w_cand;
        w_found = 1'b1;
      end
    end
  end

  // Gated by dest_almost_full combinationally so a rising flag stops the pop
  // in the same cycle; only the two words already in flight can follow it.
  assign w_pop_en = (r_state == S_ACTIVE) && !dest_almost_full && w_any_ready;
  assign pop      = w_pop_en ? (4'b0001 << w_sel) : 4'b0000;

  // ---------------------------------------------------------------------------
  // Output stage: the queue presents its word one cycle after the pop, so the
  // grant is delayed one cycle to pick the right lane for data_out.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_data_sel = fifo_data[0 +: DW];
    for (int i = 0; i < 4; i++) begin
      if (r_grant_d == 2'(i)) w_data_sel = fifo_data[i*DW +: DW];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last      <= 2'd3;
      r_pop_d     <= 1'b0;
      r_grant_d   <= 2'd0;
      r_data_out  <= '0;
      r_valid_out <= 1'b0;
      r_words_fwd <= 8'd0;
    end else begin
      r_pop_d <= w_pop_en;
      if (w_pop_en) begin
        r_grant_d <= w_sel;
        r_last    <= w_sel;
      end
      if (r_pop_d) r_data_out <= w_data_sel;
      // A popped word whose queue does not flag it valid is dropped here.
      r_valid_out <= r_pop_d & fifo_valid[r_grant_d];
      if (r_valid_out) r_words_fwd <= r_words_fwd + 8'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Threshold registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_umbral_af <= AF_DEFAULT;
      r_umbral_ae <= AE_DEFAULT;
    end else if (r_state == S_INIT) begin
      r_umbral_af <= umbral_af_in;
      r_umbral_ae <= umbral_ae_in;
    end
  end

  assign data_out      = r_data_out;
  assign valid_out     = r_valid_out;
  assign words_fwd     = r_words_fwd;
  assign umbral_af_out = r_umbral_af;
  assign umbral_ae_out = r_umbral_ae;
  assign state         = r_state;
  assign error_out     = (r_state == S_ERROR);
  assign idle          = (r_state == S_IDLE) && !r_pop_d && !r_valid_out;

endmodule

// File: tb/tb_txl_pop_scheduler.sv
module tb_txl_pop_scheduler;
  localparam int DW = 6;
  localparam logic [5:0] ST_RESET  = 6'b000001;
  localparam logic [5:0] ST_INIT   = 6'b000010;
  localparam logic [5:0] ST_IDLE   = 6'b000100;
  localparam logic [5:0] ST_ACTIVE = 6'b001000;
  localparam logic [5:0] ST_PAUSE  = 6'b010000;
  localparam logic [5:0] ST_ERROR  = 6'b100000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset, init, dest_almost_full;
  logic [3:0]      umbral_af_in, umbral_ae_in, fifo_empty, fifo_error, fifo_valid;
  logic [4*DW-1:0] fifo_data;
  logic [3:0]      pop, umbral_af_out, umbral_ae_out;
  logic [DW-1:0]   data_out;
  logic            valid_out, idle, error_out;
  logic [5:0]      state;
  logic [7:0]      words_fwd;

  txl_pop_scheduler #(.DW(DW), .AF_DEFAULT(4'd6), .AE_DEFAULT(4'd2)) dut (
    .clk(clk), .reset(reset), .init(init),
    .umbral_af_in(umbral_af_in), .umbral_ae_in(umbral_ae_in),
    .fifo_empty(fifo_empty), .fifo_error(fifo_error), .fifo_valid(fifo_valid),
    .fifo_data(fifo_data), .dest_almost_full(dest_almost_full),
    .pop(pop), .data_out(data_out), .valid_out(valid_out),
    .umbral_af_out(umbral_af_out), .umbral_ae_out(umbral_ae_out),
    .state(state), .idle(idle), .error_out(error_out), .words_fwd(words_fwd)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Queue environment: registered-read FIFOs (word appears the cycle after pop).
  logic [DW-1:0] fq [4][$];
  logic [DW-1:0] env_rd_data [4];
  logic [3:0]    env_rd_valid = 4'b0000;

  // Reference model.
  typedef struct { int due; logic v; logic [DW-1:0] d; } ent_t;
  ent_t       pipe[$];
  logic [5:0] m_state = ST_RESET;
  logic [1:0] m_last  = 2'd3;
  logic [3:0] m_af = 4'd6, m_ae = 4'd2;
  logic [7:0] m_words = 8'd0;
  bit         m_known = 0;

  logic [3:0] s_dut_pop, s_m_pop;
  bit         s_drop, s_exp_valid;
  bit         drop_en = 0;

  logic [3:0]    pop_trace[$];
  int            pop_cycles[$];
  int            valid_cycles[$];
  logic [DW-1:0] data_trace[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [3:0] env_empty();
    logic [3:0] e;
    for (int i = 0; i < 4; i++) e[i] = (fq[i].size() == 0);
    return e;
  endfunction

  function automatic logic [3:0] model_pop();
    logic [3:0] e;
    e = env_empty();
    if (m_state != ST_ACTIVE || dest_almost_full || e == 4'hf) return 4'b0000;
    for (int k = 1; k <= 4; k++) begin
      int idx;
      idx = (int'(m_last) + k) % 4;
      if (!e[idx]) return 4'b0001 << idx;
    end
    return 4'b0000;
  endfunction

  function automatic logic [5:0] model_next();
    bit any;
    any = (env_empty() != 4'hf);
    if (m_state == ST_RESET) return ST_INIT;
    if (fifo_error != 4'b0000) return ST_ERROR;
    if (m_state == ST_ERROR) return ST_ERROR;
    if (m_state == ST_INIT) return init ? ST_INIT : ST_IDLE;
    if (init) return ST_INIT;
    if (m_state == ST_IDLE) begin
      if (any) return dest_almost_full ? ST_PAUSE : ST_ACTIVE;
      return ST_IDLE;
    end
    if (m_state == ST_ACTIVE) begin
      if (dest_almost_full) return ST_PAUSE;
      if (!any) return ST_IDLE;
      return ST_ACTIVE;
    end
    if (!dest_almost_full) return any ? ST_ACTIVE : ST_IDLE;
    return ST_PAUSE;
  endfunction

  task automatic drive_env();
    fifo_empty = env_empty();
    fifo_valid = env_rd_valid;
    for (int i = 0; i < 4; i++) fifo_data[i*DW +: DW] = env_rd_data[i];
  endtask

  task automatic compare();
    logic          exp_valid, exp_pop_d;
    logic [DW-1:0] exp_data;
    exp_valid = 1'b0; exp_pop_d = 1'b0; exp_data = '0;
    s_m_pop   = model_pop();
    s_dut_pop = pop;
    s_drop    = drop_en && ($urandom_range(0, 3) == 0);
    foreach (pipe[j]) begin
      if (pipe[j].due == cyc) begin exp_valid = pipe[j].v; exp_data = pipe[j].d; end
      if (pipe[j].due == cyc + 1) exp_pop_d = 1'b1;
    end
    s_exp_valid = exp_valid;
    if (!m_known) return;
    if (pop != 4'b0000) begin pop_trace.push_back(pop); pop_cycles.push_back(cyc); end
    if (valid_out === 1'b1) begin valid_cycles.push_back(cyc); data_trace.push_back(data_out); end
    check("pop", 32'(pop), 32'(s_m_pop));
    check("state", 32'(state), 32'(m_state));
    check("valid_out", 32'(valid_out), 32'(exp_valid));
    if (exp_valid) check("data_out", 32'(data_out), 32'(exp_data));
    check("words_fwd", 32'(words_fwd), 32'(m_words));
    check("idle", 32'(idle), 32'((m_state == ST_IDLE) && !exp_pop_d && !exp_valid));
    check("error_out", 32'(error_out), 32'(m_state == ST_ERROR));
    check("umbral_af", 32'(umbral_af_out), 32'(m_af));
    check("umbral_ae", 32'(umbral_ae_out), 32'(m_ae));
  endtask

  task automatic advance();
    if (reset) begin
      m_known = 1;
      m_state = ST_RESET; m_last = 2'd3; m_words = 8'd0;
      m_af = 4'd6; m_ae = 4'd2;
      pipe.delete();
    end else if (m_known) begin
      if (s_exp_valid) m_words = m_words + 8'd1;
      while (pipe.size() > 0 && pipe[0].due <= cyc) void'(pipe.pop_front());
      if (s_m_pop != 4'b0000) begin
        ent_t e;
        for (int i = 0; i < 4; i++) if (s_m_pop[i]) m_last = 2'(i);
        e.due = cyc + 2; e.v = !s_drop; e.d = fq[m_last][0];
        pipe.push_back(e);
      end
      if (m_state == ST_INIT) begin m_af = umbral_af_in; m_ae = umbral_ae_in; end
      m_state = model_next();
    end
    for (int i = 0; i < 4; i++) begin
      env_rd_valid[i] = 1'b0;
      if (s_dut_pop[i] === 1'b1 && fq[i].size() > 0) begin
        env_rd_data[i]  = fq[i].pop_front();
        env_rd_valid[i] = !s_drop;
      end
    end
    cyc++;
  endtask

  task automatic cycle();
    drive_env();
    #1 compare();
    @(posedge clk);
    #1 advance();
    @(negedge clk);
  endtask

  task automatic drain(input string name, input int budget);
    int  n;
    bit  settled;
    n = 0;
    do begin
      cycle(); n++;
      settled = (m_state == ST_IDLE) && (pipe.size() == 0) && (env_empty() == 4'hf);
    end while (!settled && n < budget);
    check(name, 32'(settled), 32'd1);
  endtask

  task automatic clear_traces();
    pop_trace.delete(); pop_cycles.delete(); valid_cycles.delete(); data_trace.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0]    exp_rr[8];
    logic [3:0]    exp_sk[6];
    logic [DW-1:0] w1[3], w3[3];
    logic [3:0]    last_g;
    int            v0, p0, n;

    for (int i = 0; i < 4; i++) env_rd_data[i] = '0;
    reset = 1'b1; init = 1'b0; dest_almost_full = 1'b0; fifo_error = 4'b0000;
    umbral_af_in = 4'd6; umbral_ae_in = 4'd2;
    drive_env();
    @(negedge clk);

    // Reset and defaults.
    cycle(); cycle();
    reset = 1'b0;
    check("rst_state", 32'(state), 32'(6'b000001));
    check("rst_af", 32'(umbral_af_out), 32'd6);
    check("rst_ae", 32'(umbral_ae_out), 32'd2);
    check("rst_valid", 32'(valid_out), 32'd0);
    cycle();
    check("seq_init", 32'(state), 32'(6'b000010));
    cycle();
    check("seq_idle", 32'(state), 32'(6'b000100));
    check("seq_nopop", 32'(pop_trace.size()), 32'd0);

    // Round-robin fairness.
    clear_traces();
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 2; k++) fq[i].push_back(DW'($urandom));
    drain("rr_drain", 40);
    exp_rr = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd1, 4'd2, 4'd4, 4'd8};
    check("rr_npops", 32'(pop_trace.size()), 32'd8);
    for (int k = 0; k < 8 && k < pop_trace.size(); k++) check("rr_order", 32'(pop_trace[k]), 32'(exp_rr[k]));
    check("rr_nvalid", 32'(valid_cycles.size()), 32'd8);
    for (int k = 0; k < valid_cycles.size() && pop_cycles.size() > 0; k++)
      check("rr_valid_cyc", 32'(valid_cycles[k]), 32'(pop_cycles[0] + 2 + k));
    check("rr_words", 32'(words_fwd), 32'd8);
    check("rr_idle_state", 32'(state), 32'(6'b000100));

    // Skip empty queues.
    clear_traces();
    for (int k = 0; k < 3; k++) begin
      w1[k] = DW'($urandom); w3[k] = DW'($urandom);
      fq[1].push_back(w1[k]); fq[3].push_back(w3[k]);
    end
    drain("skip_drain", 40);
    exp_sk = '{4'd2, 4'd8, 4'd2, 4'd8, 4'd2, 4'd8};
    check("skip_npops", 32'(pop_trace.size()), 32'd6);
    for (int k = 0; k < 6 && k < pop_trace.size(); k++) check("skip_order", 32'(pop_trace[k]), 32'(exp_sk[k]));
    check("skip_ndata", 32'(data_trace.size()), 32'd6);
    for (int k = 0; k < 3 && 2*k+1 < data_trace.size(); k++) begin
      check("skip_data1", 32'(data_trace[2*k]), 32'(w1[k]));
      check("skip_data3", 32'(data_trace[2*k+1]), 32'(w3[k]));
    end

    // Backpressure.
    clear_traces();
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) fq[i].push_back(DW'($urandom));
    n = 0;
    while (pop_trace.size() < 3 && n < 20) begin cycle(); n++; end
    check("bp_started", 32'(pop_trace.size() >= 3), 32'd1);
    last_g = (pop_trace.size() > 0) ? pop_trace[$] : 4'd0;
    v0 = valid_cycles.size();
    dest_almost_full = 1'b1;
    cycle();
    check("bp_pop_same_cycle", 32'(s_dut_pop), 32'd0);
    check("bp_pause", 32'(state), 32'(6'b010000));
    repeat (4) cycle();
    check("bp_tail", 32'(valid_cycles.size() - v0), 32'd2);
    dest_almost_full = 1'b0;
    p0 = pop_trace.size();
    n = 0;
    while (pop_trace.size() == p0 && n < 10) begin cycle(); n++; end
    check("bp_resume_seen", 32'(pop_trace.size() > p0), 32'd1);
    if (pop_trace.size() > p0)
      check("bp_resume_q", 32'(pop_trace[p0]), 32'({last_g[2:0], last_g[3]}));
    drain("bp_drain", 60);

    // Randomized traffic with backpressure, init pulses and dropped words.
    drop_en = 1;
    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(0, 2) == 0) begin
        int q;
        q = $urandom_range(0, 3);
        if (fq[q].size() < 8) fq[q].push_back(DW'($urandom));
      end
      dest_almost_full = ($urandom_range(0, 3) == 0);
      init = ($urandom_range(0, 19) == 0);
      umbral_af_in = 4'($urandom);
      umbral_ae_in = 4'($urandom);
      cycle();
    end
    drop_en = 0; dest_almost_full = 1'b0; init = 1'b0;
    drain("rand_drain", 200);

    // Threshold load.
    umbral_af_in = 4'd5; umbral_ae_in = 4'd1;
    init = 1'b1;
    cycle();
    init = 1'b0;
    cycle();
    check("thr_af", 32'(umbral_af_out), 32'd5);
    check("thr_ae", 32'(umbral_ae_out), 32'd1);
    check("thr_state", 32'(state), 32'(6'b000100));
    cycle();

    // Error and recovery.
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 3; k++) fq[i].push_back(DW'($urandom));
    repeat (3) cycle();
    fifo_error = 4'b0100;
    cycle();
    fifo_error = 4'b0000;
    check("err_state", 32'(state), 32'(6'b100000));
    check("err_out", 32'(error_out), 32'd1);
    cycle();
    check("err_nopop", 32'(s_dut_pop), 32'd0);
    repeat (3) cycle();
    check("err_sticky", 32'(error_out), 32'd1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("rec_state", 32'(state), 32'(6'b000001));
    check("rec_words", 32'(words_fwd), 32'd0);
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
